// File: rtl/encoder8to3_scan_if.sv
// Handshake bundle for encoder8to3_scan: vector input channel, index output channel, busy status.
interface encoder8to3_scan_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       busy;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, busy
    );
endinterface

// File: rtl/encoder8to3_scan.sv
// Sequential 8-to-3 encoder: emits the index of every set request bit, one per handshake, in priority order.
// Optional macro ENC_ZERO_ERR_EN adds a one-cycle err pulse after an all-zero vector is accepted.
module encoder8to3_scan #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic clk,
    input  logic rst,
`ifdef ENC_ZERO_ERR_EN
    output logic err,
`endif
    encoder8to3_scan_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] pending_r;
    logic [7:0] pending_nxt_s;
    logic       in_ready_r;
    logic       out_valid_r;
    logic [2:0] out_idx_r;
    logic       out_last_r;
    logic       busy_r;
`ifdef ENC_ZERO_ERR_EN
    logic       zero_take_s;
    logic       err_r;
`endif

    // Index of the highest-priority set bit; 0 when nothing is pending.
    function automatic logic [2:0] prio_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) begin
                    idx = 3'(i);
                end else begin
                    idx = idx;
                end
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) begin
                    idx = 3'(i);
                end else begin
                    idx = idx;
                end
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [7:0] vec);
        return (vec != 8'd0) && ((vec & (vec - 8'd1)) == 8'd0);
    endfunction

    // Next-state and next-pending decode.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
`ifdef ENC_ZERO_ERR_EN
        zero_take_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_vec != 8'd0) begin
                        pending_nxt_s = bus.in_vec;
                        state_nxt_s   = SCAN;
                    end else begin
`ifdef ENC_ZERO_ERR_EN
                        zero_take_s   = 1'b1;
`endif
                        state_nxt_s   = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pending_nxt_s = pending_r & ~(8'd1 << out_idx_r);
                    if (out_last_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = SCAN;
                    end
                end else begin
                    pending_nxt_s = pending_r;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                pending_nxt_s = 8'd0;
            end
        endcase
    end

    // State, pending vector and outputs, all precomputed from next state so outputs stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            pending_r   <= 8'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_idx_r   <= 3'd0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pending_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == SCAN);
            out_idx_r   <= prio_idx(pending_nxt_s);
            out_last_r  <= is_onehot(pending_nxt_s);
            busy_r      <= (state_nxt_s == SCAN);
        end
    end

`ifdef ENC_ZERO_ERR_EN
    // One-cycle pulse after a zero vector is consumed in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= zero_take_s;
        end
    end

    assign err = err_r;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_encoder8to3_scan.sv
// Directed bench for encoder8to3_scan: LSB-first and MSB-first instances, backpressure, reset, zero vectors.
module tb_encoder8to3_scan;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    encoder8to3_scan_if ifa ();
    encoder8to3_scan_if ifb ();

`ifdef ENC_ZERO_ERR_EN
    logic erra;
    logic errb;
`endif

    encoder8to3_scan #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
`ifdef ENC_ZERO_ERR_EN
        .err (erra),
`endif
        .bus (ifa)
    );

    encoder8to3_scan #(.MSB_FIRST(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
`ifdef ENC_ZERO_ERR_EN
        .err (errb),
`endif
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [2:0] idx, input logic last,
                         input logic rdy, input logic bsy);
        chk({tag, ".out_valid"}, {7'd0, ifa.out_valid}, {7'd0, v});
        chk({tag, ".out_idx"},   {5'd0, ifa.out_idx},   {5'd0, idx});
        chk({tag, ".out_last"},  {7'd0, ifa.out_last},  {7'd0, last});
        chk({tag, ".in_ready"},  {7'd0, ifa.in_ready},  {7'd0, rdy});
        chk({tag, ".busy"},      {7'd0, ifa.busy},      {7'd0, bsy});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_vec = 8'h00; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.in_vec = 8'h00; ifb.out_ready = 1'b0;
        #12;
        chk_a("reset", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        step();
        chk_a("idle", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // LSB-first ordering of 1010_0100 with out_ready held high
        ifa.in_valid = 1'b1; ifa.in_vec = 8'b1010_0100; ifa.out_ready = 1'b1;
        step();
        ifa.in_valid = 1'b0; ifa.in_vec = 8'h00;
        chk_a("lsb0", 1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        step();
        chk_a("lsb1", 1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        step();
        chk_a("lsb2", 1'b1, 3'd7, 1'b1, 1'b0, 1'b1);
        step();
        chk_a("lsb_done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Backpressure on 0001_0010
        ifa.in_valid = 1'b1; ifa.in_vec = 8'b0001_0010; ifa.out_ready = 1'b0;
        step();
        ifa.in_valid = 1'b0; ifa.in_vec = 8'h00;
        for (int k = 0; k < 5; k++) begin
            chk_a("bp_hold", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
            step();
        end
        chk_a("bp_hold_end", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        ifa.out_ready = 1'b1;
        step();
        chk_a("bp_last", 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
        step();
        chk_a("bp_done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Input offered during SCAN must be ignored
        ifa.in_valid = 1'b1; ifa.in_vec = 8'h06;
        step();
        ifa.in_vec = 8'h80;
        chk_a("busy0", 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        step();
        ifa.in_valid = 1'b0; ifa.in_vec = 8'h00;
        chk_a("busy1", 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        step();
        chk_a("busy_done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk_a("busy_nocap", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Zero vector is dropped
        ifa.in_valid = 1'b1; ifa.in_vec = 8'h00;
        step();
        ifa.in_valid = 1'b0;
        chk_a("zero0", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
`ifdef ENC_ZERO_ERR_EN
        chk("zero.err_pulse", {7'd0, erra}, 8'd1);
`endif
        step();
        chk_a("zero1", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
`ifdef ENC_ZERO_ERR_EN
        chk("zero.err_clear", {7'd0, erra}, 8'd0);
`endif

        // One-hot vector gives a single last output
        ifa.in_valid = 1'b1; ifa.in_vec = 8'h40;
        step();
        ifa.in_valid = 1'b0; ifa.in_vec = 8'h00;
        chk_a("onehot", 1'b1, 3'd6, 1'b1, 1'b0, 1'b1);
        step();
        chk_a("onehot_done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-scan discards the vector
        ifa.in_valid = 1'b1; ifa.in_vec = 8'b1010_0100;
        step();
        ifa.in_valid = 1'b0; ifa.in_vec = 8'h00;
        chk_a("mid0", 1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        step();
        chk_a("mid1", 1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_a("mid_rst", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        ifa.in_valid = 1'b1; ifa.in_vec = 8'h01;
        step();
        ifa.in_valid = 1'b0; ifa.in_vec = 8'h00;
        chk_a("post_rst", 1'b1, 3'd0, 1'b1, 1'b0, 1'b1);
        step();
        chk_a("post_rst_done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // MSB-first ordering of 8'hFF on the second instance
        ifb.in_valid = 1'b1; ifb.in_vec = 8'hFF; ifb.out_ready = 1'b1;
        step();
        ifb.in_valid = 1'b0; ifb.in_vec = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            chk("msb.out_valid", {7'd0, ifb.out_valid}, 8'd1);
            chk("msb.out_idx", {5'd0, ifb.out_idx}, 8'(i));
            chk("msb.out_last", {7'd0, ifb.out_last}, (i == 0) ? 8'd1 : 8'd0);
            step();
        end
        chk("msb_done.out_valid", {7'd0, ifb.out_valid}, 8'd0);
        chk("msb_done.in_ready", {7'd0, ifb.in_ready}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
